traffic_ctrl_multi: RTL and testbench
=====================================

Name: traffic_ctrl_multi

Overview:
- Parametrised N-approach traffic light controller. It sequences green → yellow → all-red across NUM_DIR approaches in round-robin order.
- Phase lengths are adjustable at run time through a mode select and three debounced buttons.
- Runs entirely in the clk_i domain; the 1 s timebase arrives as a single-cycle enable pulse, not a clock.
- Sits between the board switch/button inputs and the per-approach RGB LEDs plus the countdown display.

Parameters:
- NUM_DIR, 2, number of approaches (2..8).
- TIME_SZ, 4, width of countdown and phase-length registers.
- DB_CYCLES, 33554431, button lockout length in clk_i cycles after an accepted press.
- DEFAULT_G, 4'd5, reset/default green length.
- DEFAULT_Y, 4'd2, reset/default yellow length.
- DEFAULT_R, 4'd1, reset/default all-red length.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- tick_i  in  1  one-cycle 1 Hz enable pulse.
- mode_i  in  2  0 = NORMAL, 1 = ADJ_G, 2 = ADJ_Y, 3 = ADJ_R.
- btn_i  in  3  [0] restore default, [1] +1, [2] -1; level, already synchronised.
- ped_i  in  NUM_DIR  pedestrian request per approach (used only with PED_REQ_EN).
- light_o  out  3*NUM_DIR  RGB per approach; approach k occupies bits [3k+2:3k].
- count_o  out  TIME_SZ  displayed value, registered.
- dir_o  out  $clog2(NUM_DIR)  approach currently holding right-of-way.

Behaviour:
- Colour codes: RED = 3'b100, YELLOW = 3'b110, GREEN = 3'b010, WHITE = 3'b111.
- FSM phase states: GREEN → YELLOW → ALLRED → GREEN, with dir incremented on the ALLRED → GREEN transition. dir wraps from NUM_DIR-1 to 0.
- Reset values: phase = GREEN, dir = 0, ctime = DEFAULT_G, glen/ylen/rlen = defaults, lockout counter = ready, count_o = DEFAULT_G, light_o = approach 0 GREEN and all others RED.
- Everything ignores cycles where tick_i = 0.
- On tick_i with ctime != 0: ctime decrements.
- On tick_i with ctime == 0: phase advances and ctime loads the new phase's length, read from the register value before any same-cycle adjustment.
  - Each phase therefore lasts len+1 ticks.
  - len = 0 gives 1 tick.
- The sequence keeps running in every mode_i. Adjusted lengths take effect at the next load; ctime is never rewritten by an adjustment.
- Button handling:
  - Evaluated only when mode_i != NORMAL and the lockout counter is ready.
  - Priority: btn_i[0] > btn_i[1] > btn_i[2]; only one action per press.
  - An accepted press starts a lockout of DB_CYCLES cycles; no further press is accepted until it expires.
  - Action applies to the register selected by mode_i: default → load its DEFAULT_x value; +1 → saturate at 2^TIME_SZ-1; -1 → saturate at 0.
  - In NORMAL mode presses are ignored and no lockout is started.
- count_o, updated every clk_i cycle (1-cycle latency):
  - NORMAL → ctime.
  - ADJ_G → glen.
  - ADJ_Y → ylen.
  - ADJ_R → rlen.
- light_o, combinational from phase/dir/mode_i:
  - NORMAL: the approach at dir shows GREEN in the GREEN phase, YELLOW in the YELLOW phase, RED in ALLRED; all other approaches show RED.
  - ADJ_G: approach 0 GREEN, others RED.
  - ADJ_Y: all YELLOW.
  - ADJ_R: all WHITE.
- dir_o = dir.
- Reset asserted mid-phase or mid-lockout immediately restores all reset values, including default lengths.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- Defined: a pedestrian request latch per approach.
  - Latch k sets on ped_i[k] = 1.
  - Latch k clears when approach k enters GREEN, and on reset.
  - Green truncation: while the phase is GREEN and any latch other than dir's is set, if ctime > 2 the next tick loads ctime = 2 instead of decrementing.
  - Request pending from ped_i[dir] in the current GREEN: no effect.
  - ped_req_o (out, NUM_DIR) reflects the latches.
- Not defined: ped_i is ignored, ped_req_o is absent, and timing is exactly as above.

Test Plan (NUM_DIR = 3, DB_CYCLES = 4 unless noted):
- Reset, then 50 ticks in NORMAL → approach 0 GREEN for 6 ticks, YELLOW for 3, all-red for 2; dir_o goes 0 → 1 → 2 → 0; count_o follows 5..0, 2..0, 1..0.
- ADJ_Y with btn_i[1] held for 20 cycles → ylen increments once per 5 cycles (press + 4 lockout); ylen saturates at 15 after repeated presses; count_o = ylen.
- ADJ_R with btn_i[2] pressed three times → rlen = 0 (saturates, no wrap). Back in NORMAL → all-red lasts 1 tick.
- ADJ_G with btn_i[0] and btn_i[1] asserted together after glen = 9 → glen = 5 (default wins); only one lockout started.
- rst_i pulsed mid-YELLOW with glen = 12 → same cycle: light_o = approach 0 GREEN, count_o = 5; glen back to 5.
- With TRAFFIC_PED_REQ_EN: ped_i[2] pulsed while dir = 0, GREEN, ctime = 4 → next tick ctime = 2; ped_req_o[2] = 1 until approach 2 goes GREEN.

Source files
------------

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: N-approach round-robin traffic light controller.
// Each approach in turn gets green -> yellow -> all-red. Phase lengths can be
// adjusted at run time through mode_i and three buttons with a lockout.
// Optional feature macro: TRAFFIC_PED_REQ_EN (pedestrian request latches
// that shorten the current green to 2 when another approach is waiting).
module traffic_ctrl_multi #(
    parameter int NUM_DIR   = 2,
    parameter int TIME_SZ   = 4,
    parameter int DB_CYCLES = 33554431,
    parameter logic [TIME_SZ-1:0] DEFAULT_G = TIME_SZ'(5),
    parameter logic [TIME_SZ-1:0] DEFAULT_Y = TIME_SZ'(2),
    parameter logic [TIME_SZ-1:0] DEFAULT_R = TIME_SZ'(1),
    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tick_i,
    input  logic [1:0]             mode_i,
    input  logic [2:0]             btn_i,
    input  logic [NUM_DIR-1:0]     ped_i,
    output logic [3*NUM_DIR-1:0]   light_o,
    output logic [TIME_SZ-1:0]     count_o,
    output logic [DIR_W-1:0]       dir_o
`ifdef TRAFFIC_PED_REQ_EN
    ,
    output logic [NUM_DIR-1:0]     ped_req_o
`endif
);

    localparam int LOCK_W = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;

    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_ALLRED = 2'd2;

    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_ADJ_G  = 2'd1;
    localparam logic [1:0] M_ADJ_Y  = 2'd2;
    localparam logic [1:0] M_ADJ_R  = 2'd3;

    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_WHITE  = 3'b111;

    logic [1:0]         phase;
    logic [DIR_W-1:0]   dir, next_dir;
    logic [TIME_SZ-1:0] ctime, glen, ylen, rlen;
    logic [LOCK_W-1:0]  lock;
    logic               load, press, trunc;
    logic [2:0]         phase_colour;

    // Default -> restore, +1 saturates high, -1 saturates at zero.
    function automatic logic [TIME_SZ-1:0] adjust(input logic [TIME_SZ-1:0] cur,
                                                  input logic [TIME_SZ-1:0] dflt,
                                                  input logic [2:0]         btn);
        if (btn[0])      return dflt;
        else if (btn[1]) return (&cur) ? cur : cur + 1'b1;
        else             return (cur == '0) ? cur : cur - 1'b1;
    endfunction

    assign load     = tick_i && (ctime == '0);
    assign next_dir = (dir == DIR_W'(NUM_DIR - 1)) ? '0 : dir + 1'b1;
    assign press    = (mode_i != M_NORMAL) && (lock == '0) && (btn_i != 3'b000);
    assign dir_o    = dir;

`ifdef TRAFFIC_PED_REQ_EN
    logic [NUM_DIR-1:0] ped_req, dir_mask, clr_mask;
    assign dir_mask  = NUM_DIR'(1) << dir;
    // The approach about to receive green has its request served.
    assign clr_mask  = (load && phase == PH_ALLRED) ? (NUM_DIR'(1) << next_dir) : '0;
    assign trunc     = (phase == PH_GREEN) && (|(ped_req & ~dir_mask)) && (ctime > TIME_SZ'(2));
    assign ped_req_o = ped_req;

    // Request latches: set by ped_i, cleared when that approach goes green.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ped_req <= '0;
        else       ped_req <= (ped_req | ped_i) & ~clr_mask;
    end
`else
    logic unused_ped;
    assign unused_ped = ^ped_i;
    assign trunc      = 1'b0;
`endif

    // Phase sequencer; loads read the lengths as they were before this cycle's button action.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase <= PH_GREEN;
            dir   <= '0;
            ctime <= DEFAULT_G;
        end else if (tick_i) begin
            if (ctime == '0) begin
                case (phase)
                    PH_GREEN:  begin phase <= PH_YELLOW; ctime <= ylen; end
                    PH_YELLOW: begin phase <= PH_ALLRED; ctime <= rlen; end
                    default:   begin phase <= PH_GREEN;  ctime <= glen; dir <= next_dir; end
                endcase
            end else if (trunc) begin
                ctime <= TIME_SZ'(2);
            end else begin
                ctime <= ctime - 1'b1;
            end
        end
    end

    // Button lockout: counts down from DB_CYCLES after every accepted press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          lock <= '0;
        else if (press)     lock <= LOCK_W'(DB_CYCLES);
        else if (lock != '0) lock <= lock - 1'b1;
    end

    // Phase length registers, edited only in the matching adjust mode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            glen <= DEFAULT_G;
            ylen <= DEFAULT_Y;
            rlen <= DEFAULT_R;
        end else if (press) begin
            case (mode_i)
                M_ADJ_G: glen <= adjust(glen, DEFAULT_G, btn_i);
                M_ADJ_Y: ylen <= adjust(ylen, DEFAULT_Y, btn_i);
                M_ADJ_R: rlen <= adjust(rlen, DEFAULT_R, btn_i);
                default: ;
            endcase
        end
    end

    // Registered display: countdown in NORMAL, the selected length otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_o <= DEFAULT_G;
        else begin
            case (mode_i)
                M_NORMAL: count_o <= ctime;
                M_ADJ_G:  count_o <= glen;
                M_ADJ_Y:  count_o <= ylen;
                default:  count_o <= rlen;
            endcase
        end
    end

    // Colour of the approach holding right-of-way in NORMAL mode.
    always_comb begin
        case (phase)
            PH_GREEN:  phase_colour = C_GREEN;
            PH_YELLOW: phase_colour = C_YELLOW;
            default:   phase_colour = C_RED;
        endcase
    end

    // Per-approach LEDs; adjust modes show which length is being edited.
    always_comb begin
        for (int k = 0; k < NUM_DIR; k++) begin
            light_o[3*k +: 3] = C_RED;
            case (mode_i)
                M_NORMAL: if (dir == DIR_W'(k)) light_o[3*k +: 3] = phase_colour;
                M_ADJ_G:  if (k == 0) light_o[3*k +: 3] = C_GREEN;
                M_ADJ_Y:  light_o[3*k +: 3] = C_YELLOW;
                default:  light_o[3*k +: 3] = C_WHITE;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi (NUM_DIR = 3, DB_CYCLES = 4). A reference model
// of phases, lengths and button lockout is checked against the DUT on every
// negedge; directed sections pin the model with hand-computed literals.
`timescale 1ns/1ps
module tb_traffic_ctrl_multi;

    localparam int N  = 3;
    localparam int TS = 4;
    localparam int DB = 4;

    logic           clk = 1'b0;
    logic           rst, tick;
    logic [1:0]     mode;
    logic [2:0]     btn;
    logic [N-1:0]   ped;
    logic [3*N-1:0] light;
    logic [TS-1:0]  count;
    logic [1:0]     dir;
`ifdef TRAFFIC_PED_REQ_EN
    logic [N-1:0]   ped_req;
`endif

    traffic_ctrl_multi #(
        .NUM_DIR(N), .TIME_SZ(TS), .DB_CYCLES(DB),
        .DEFAULT_G(4'd5), .DEFAULT_Y(4'd2), .DEFAULT_R(4'd1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .mode_i(mode), .btn_i(btn),
        .ped_i(ped), .light_o(light), .count_o(count), .dir_o(dir)
`ifdef TRAFFIC_PED_REQ_EN
        , .ped_req_o(ped_req)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0=green 1=yellow 2=all-red; len[] indexed by phase.
    int         m_phase, m_dir, m_ct, m_lock, m_count;
    int         m_len[3];
    int         dflt[3] = '{5, 2, 1};
    logic [N-1:0] m_ped;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_light(input int ph, input int d, input int md);
        logic [3*N-1:0] v;
        logic [2:0] c;
        v = '0;
        for (int k = 0; k < N; k++) begin
            c = 3'b100;
            case (md)
                0: if (k == d) c = (ph == 0) ? 3'b010 : (ph == 1) ? 3'b110 : 3'b100;
                1: if (k == 0) c = 3'b010;
                2: c = 3'b110;
                default: c = 3'b111;
            endcase
            v[3*k +: 3] = c;
        end
        return int'(v);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dir = 0; m_ct = 5; m_lock = 0; m_count = 5;
        for (int i = 0; i < 3; i++) m_len[i] = dflt[i];
        m_ped = '0;
    endtask

    // Advance the model across the coming posedge using the inputs now applied.
    task automatic model_step();
        int nph, nct, ndir, md, idx;
        bit tr;
        md = int'(mode);
        m_count = (md == 0) ? m_ct : m_len[md-1];
        nph = m_phase; nct = m_ct; ndir = m_dir;
        tr = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        for (int k = 0; k < N; k++)
            if (k != m_dir && m_ped[k]) tr = (m_phase == 0) && (m_ct > 2);
`endif
        if (tick) begin
            if (m_ct == 0) begin
                nph = (m_phase + 1) % 3;
                if (nph == 0) ndir = (m_dir + 1) % N;
                nct = m_len[nph];
            end else if (tr) nct = 2;
            else nct = m_ct - 1;
        end
`ifdef TRAFFIC_PED_REQ_EN
        m_ped = m_ped | ped;
        if (tick && m_ct == 0 && m_phase == 2) m_ped[ndir] = 1'b0;
`endif
        if (md != 0 && m_lock == 0 && btn != 3'b000) begin
            idx = md - 1;
            if (btn[0])      m_len[idx] = dflt[idx];
            else if (btn[1]) m_len[idx] = (m_len[idx] >= 15) ? 15 : m_len[idx] + 1;
            else             m_len[idx] = (m_len[idx] <= 0) ? 0 : m_len[idx] - 1;
            m_lock = DB;
        end else if (m_lock > 0) m_lock--;
        m_phase = nph; m_ct = nct; m_dir = ndir;
    endtask

    // Compare process: outputs against model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("count_o", int'(count), m_count);
            chk("dir_o", int'(dir), m_dir);
            chk("light_o", int'(light), exp_light(m_phase, m_dir, int'(mode)));
`ifdef TRAFFIC_PED_REQ_EN
            chk("ped_req_o", int'(ped_req), int'(m_ped));
`endif
            if (!rst) model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
    endtask

    task automatic press(input logic [2:0] b);
        btn = b; cyc(); btn = 3'b000; repeat (5) cyc();
    endtask

    task automatic hold(input logic [2:0] b, input int n);
        btn = b;
        repeat (n) begin
            tick = 1'($urandom_range(0, 1));
            cyc();
        end
        btn = 3'b000; tick = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; tick = 1'b0; mode = 2'd0; btn = 3'b000; ped = '0;
        cyc(); cyc();
        chk("rst_light", int'(light), 9'b100100010);
        chk("rst_count", int'(count), 5);
        chk("rst_dir", int'(dir), 0);
        rst = 1'b0;
        cyc();

        // NORMAL: one full approach cycle with literal checkpoints.
        for (int i = 1; i <= 11; i++) begin
            tick_once();
            if (i == 6) begin
                chk("yel_light", int'(light), 9'b100100110);
                chk("yel_count", int'(count), 2);
            end
            if (i == 11) begin
                chk("dir1", int'(dir), 1);
                chk("g1_light", int'(light), 9'b100010100);
                chk("g1_count", int'(count), 5);
            end
        end
        for (int i = 0; i < 39; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end

        // ADJ_Y: held +1 increments once per 5 cycles, then saturates.
        mode = 2'd2;
        hold(3'b010, 20);
        cyc();
        chk("ylen_6", int'(count), 6);
        chk("adjy_light", int'(light), 9'b110110110);
        hold(3'b010, 60);
        cyc();
        chk("ylen_sat15", int'(count), 15);

        // ADJ_R: -1 three times saturates at zero.
        repeat (6) cyc();
        mode = 2'd3;
        press(3'b100); press(3'b100); press(3'b100);
        chk("rlen_0", int'(count), 0);
        chk("adjr_light", int'(light), 9'b111111111);
        mode = 2'd0;
        repeat (40) tick_once();

        // ADJ_G: default beats +1, single lockout for a held combo.
        mode = 2'd1;
        repeat (6) cyc();
        press(3'b010); press(3'b010); press(3'b010); press(3'b010);
        chk("glen_9", int'(count), 9);
        chk("adjg_light", int'(light), 9'b100100010);
        btn = 3'b011; repeat (3) cyc();
        btn = 3'b010; cyc();
        btn = 3'b000; repeat (5) cyc();
        chk("glen_dflt", int'(count), 5);

        // Reset mid-yellow with glen = 12.
        for (int i = 0; i < 7; i++) press(3'b010);
        chk("glen_12", int'(count), 12);
        mode = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_phase == 1 && m_ct == 1) found = 1'b1;
            else tick_once();
        end
        chk("reach_yellow", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_light", int'(light), 9'b100100010);
        chk("mid_rst_count", int'(count), 5);
        chk("mid_rst_dir", int'(dir), 0);
        cyc();
        rst = 1'b0;
        mode = 2'd1;
        cyc(); cyc();
        chk("glen_after_rst", int'(count), 5);

        // Randomised traffic across modes, buttons, ticks and resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            btn  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick = ($urandom_range(0, 2) == 0);
            ped  = ($urandom_range(0, 15) == 0) ? N'($urandom_range(0, 7)) : '0;
            rst  = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0; tick = 1'b0; btn = 3'b000; ped = '0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
